// File: rtl/qos_fifo_bank.sv
// qos_fifo_bank: NCH independent circular FIFO channels sharing one clock.
// Writes are steered by QoS (with optional spill to lower channels), and reads
// are granted by a strict-priority arbiter with a starvation-relief override.
// The highest channel index has the highest priority.
module qos_fifo_bank #(
    parameter int DSIZE  = 32,
    parameter int NCH    = 4,
    parameter int QSIZE  = 2,
    parameter int ASIZE  = 2,
    parameter int SPILL  = 1,
    parameter int STARVE = 8
) (
    input  logic             iClk,
    input  logic             iResetn,
    input  logic             iWr,
    input  logic [DSIZE-1:0] iWrData,
    input  logic [QSIZE-1:0] iQoS,
    output logic             oFull,
    output logic             oDrop,
    input  logic             iRd,
    output logic             oRdValid,
    output logic [DSIZE-1:0] oRdData,
    output logic [QSIZE-1:0] oRdQoS,
    output logic [NCH-1:0]   oEmpty
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int SW    = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [ASIZE:0]  FULL_CNT   = (ASIZE + 1)'(DEPTH);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE);
    localparam logic [CW-1:0]   TOP_CH     = CW'(NCH - 1);

    // Index of the highest set bit; zero when the vector is empty (callers
    // always qualify the result with an OR-reduction of the same vector).
    function automatic logic [CW-1:0] find_hi(input logic [NCH-1:0] vec);
        logic [CW-1:0] idx;
        idx = {CW{1'b0}};
        for (int c = 0; c < NCH; c++) begin
            if (vec[c]) begin
                idx = CW'(c);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Channel storage and bookkeeping
    logic [DSIZE-1:0] mem_r     [NCH][DEPTH];
    logic [ASIZE-1:0] wr_ptr_r  [NCH];
    logic [ASIZE-1:0] rd_ptr_r  [NCH];
    logic [ASIZE:0]   count_r   [NCH];
    logic [SW-1:0]    starve_r  [NCH];

    logic [ASIZE:0]   count_nxt_s  [NCH];
    logic [SW-1:0]    starve_nxt_s [NCH];

    // Status, steering and arbitration
    logic [CW-1:0]    q_s;
    logic [NCH-1:0]   full_s;
    logic [NCH-1:0]   cand_s;
    logic [NCH-1:0]   starving_s;
    logic [NCH-1:0]   ok_s;
    logic             tgt_found_s;
    logic [CW-1:0]    tgt_s;
    logic             gnt_valid_s;
    logic [CW-1:0]    gnt_s;
    logic [NCH-1:0]   wr_en_s;
    logic [NCH-1:0]   rd_en_s;
    logic [DSIZE-1:0] rd_data_s;

    // Clamp the requested QoS into the legal channel range.
    always_comb begin
        if (32'(iQoS) >= 32'(NCH)) begin
            q_s = TOP_CH;
        end else begin
            q_s = CW'(iQoS);
        end
    end

    // Per-channel status from the counts at the start of the cycle.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            full_s[c]     = (count_r[c] == FULL_CNT);
            cand_s[c]     = (count_r[c] != {(ASIZE + 1){1'b0}});
            starving_s[c] = (STARVE > 0) && cand_s[c] && (starve_r[c] == STARVE_MAX);
        end
    end

    // Write steering: eligible channels are non-full and at or below the
    // clamped QoS (only the QoS channel itself without spill). The highest
    // eligible index is the first hit when walking downward from q.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            ok_s[c] = !full_s[c] && (CW'(c) <= q_s) && ((SPILL != 0) || (CW'(c) == q_s));
        end
        tgt_found_s = |ok_s;
        tgt_s       = find_hi(ok_s);
    end

    // Read arbitration: starving channels first, else strict priority.
    always_comb begin
        gnt_valid_s = iRd && (|cand_s);
        if (|starving_s) begin
            gnt_s = find_hi(starving_s);
        end else begin
            gnt_s = find_hi(cand_s);
        end
    end

    // Per-channel write/pop strobes and the data at the granted head.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            wr_en_s[c] = iWr && tgt_found_s && (tgt_s == CW'(c));
            rd_en_s[c] = gnt_valid_s && (gnt_s == CW'(c));
        end
        rd_data_s = mem_r[gnt_s][rd_ptr_r[gnt_s]];
    end

    // Next count and next starvation counter for each channel.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            case ({wr_en_s[c], rd_en_s[c]})
                2'b10:   count_nxt_s[c] = count_r[c] + 1'b1;
                2'b01:   count_nxt_s[c] = count_r[c] - 1'b1;
                default: count_nxt_s[c] = count_r[c];
            endcase

            if (count_nxt_s[c] == {(ASIZE + 1){1'b0}}) begin
                starve_nxt_s[c] = {SW{1'b0}};
            end else if (rd_en_s[c]) begin
                starve_nxt_s[c] = {SW{1'b0}};
            end else if (gnt_valid_s && cand_s[c] && (starve_r[c] != STARVE_MAX)) begin
                starve_nxt_s[c] = starve_r[c] + 1'b1;
            end else begin
                starve_nxt_s[c] = starve_r[c];
            end
        end
    end

    // Pointer, count and starvation counter registers.
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr_r[c] <= {ASIZE{1'b0}};
                rd_ptr_r[c] <= {ASIZE{1'b0}};
                count_r[c]  <= {(ASIZE + 1){1'b0}};
                starve_r[c] <= {SW{1'b0}};
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (wr_en_s[c]) begin
                    wr_ptr_r[c] <= wr_ptr_r[c] + 1'b1;
                end
                if (rd_en_s[c]) begin
                    rd_ptr_r[c] <= rd_ptr_r[c] + 1'b1;
                end
                count_r[c]  <= count_nxt_s[c];
                starve_r[c] <= starve_nxt_s[c];
            end
        end
    end

    // Data storage; contents are only observed behind a valid count.
    always_ff @(posedge iClk) begin
        for (int c = 0; c < NCH; c++) begin
            if (wr_en_s[c]) begin
                mem_r[c][wr_ptr_r[c]] <= iWrData;
            end
        end
    end

    // Registered read response and drop pulse.
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            oRdValid <= 1'b0;
            oRdData  <= {DSIZE{1'b0}};
            oRdQoS   <= {QSIZE{1'b0}};
            oDrop    <= 1'b0;
        end else begin
            oRdValid <= gnt_valid_s;
            oRdData  <= gnt_valid_s ? rd_data_s : {DSIZE{1'b0}};
            oRdQoS   <= gnt_valid_s ? QSIZE'(gnt_s) : {QSIZE{1'b0}};
            oDrop    <= iWr && !tgt_found_s;
        end
    end

    assign oFull  = !tgt_found_s;
    assign oEmpty = ~cand_s;

endmodule

// File: tb/tb_qos_fifo_bank.sv
// Bench for qos_fifo_bank: two instances (spill+starve=3, no-spill+starve=0)
// share stimulus; a queue-based reference model per instance predicts
// responses into scoreboards that a separate monitor drains.
module tb_qos_fifo_bank;

    localparam int NC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [2:0]  qos = 3'd0;

    logic        full_o  [NC];
    logic        drop_o  [NC];
    logic        rdv_o   [NC];
    logic [31:0] rdd_o   [NC];
    logic [2:0]  rdq_o   [NC];
    logic [3:0]  empty_o [NC];

    always #5 clk = ~clk;

    qos_fifo_bank #(.DSIZE(32), .NCH(4), .QSIZE(3), .ASIZE(2), .SPILL(1), .STARVE(3)) dut_a (
        .iClk(clk), .iResetn(rst_n), .iWr(wr), .iWrData(wdata), .iQoS(qos),
        .oFull(full_o[0]), .oDrop(drop_o[0]), .iRd(rd), .oRdValid(rdv_o[0]),
        .oRdData(rdd_o[0]), .oRdQoS(rdq_o[0]), .oEmpty(empty_o[0])
    );

    qos_fifo_bank #(.DSIZE(32), .NCH(4), .QSIZE(3), .ASIZE(2), .SPILL(0), .STARVE(0)) dut_b (
        .iClk(clk), .iResetn(rst_n), .iWr(wr), .iWrData(wdata), .iQoS(qos),
        .oFull(full_o[1]), .oDrop(drop_o[1]), .iRd(rd), .oRdValid(rdv_o[1]),
        .oRdData(rdd_o[1]), .oRdQoS(rdq_o[1]), .oEmpty(empty_o[1])
    );

    typedef struct packed {
        logic [31:0] stamp;
        logic [31:0] data;
        logic [2:0]  ch;
    } rd_exp_t;

    // Reference model state: one queue per channel plus starvation counts.
    logic [31:0] mq [NC][4][$];
    int          sc [NC][4];

    // Scoreboards: expected reads and expected drop cycles.
    rd_exp_t     exp_rd   [NC][$];
    int          exp_drop [NC][$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_spill(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int cfg_starve(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, req);
        end
    endtask

    // Predict one cycle of behaviour for instance k from the current inputs.
    task automatic model_step(input int k);
        int q;
        int tgt;
        int g;
        bit ne [4];
        logic [31:0] d;
        rd_exp_t e;
        q = (int'(qos) >= 4) ? 3 : int'(qos);
        tgt = -1;
        for (int c = q; c >= 0; c--) begin
            if (tgt < 0 && mq[k][c].size() < 4 && (cfg_spill(k) == 1 || c == q)) tgt = c;
        end
        chk("full", k, 64'(full_o[k]), 64'(tgt < 0));
        for (int c = 0; c < 4; c++) ne[c] = (mq[k][c].size() > 0);
        g = -1;
        if (rd) begin
            if (cfg_starve(k) > 0) begin
                for (int c = 0; c < 4; c++) if (ne[c] && sc[k][c] == cfg_starve(k)) g = c;
            end
            if (g < 0) begin
                for (int c = 0; c < 4; c++) if (ne[c]) g = c;
            end
        end
        if (g >= 0) begin
            d = mq[k][g].pop_front();
            e.stamp = 32'(cyc + 1);
            e.data  = d;
            e.ch    = 3'(g);
            exp_rd[k].push_back(e);
            for (int c = 0; c < 4; c++) begin
                if (c == g) sc[k][c] = 0;
                else if (ne[c] && sc[k][c] < cfg_starve(k)) sc[k][c]++;
            end
        end
        if (wr) begin
            if (tgt >= 0) mq[k][tgt].push_back(wdata);
            else exp_drop[k].push_back(cyc + 1);
        end
        for (int c = 0; c < 4; c++) if (mq[k][c].size() == 0) sc[k][c] = 0;
    endtask

    // One stimulus cycle: check empties, drive inputs, check oFull and predict.
    task automatic step(input bit w, input logic [31:0] d, input logic [2:0] q, input bit r);
        logic [3:0] ex;
        @(negedge clk);
        for (int k = 0; k < NC; k++) begin
            for (int c = 0; c < 4; c++) ex[c] = (mq[k][c].size() == 0);
            chk("empty", k, 64'(empty_o[k]), 64'(ex));
        end
        wr = w; wdata = d; qos = q; rd = r;
        #1;
        for (int k = 0; k < NC; k++) model_step(k);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 3'd0, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int k = 0; k < NC; k++) begin
            chk({tag, "_valid"}, k, 64'(rdv_o[k]), 64'(0));
            chk({tag, "_data"},  k, 64'(rdd_o[k]), 64'(0));
            chk({tag, "_qos"},   k, 64'(rdq_o[k]), 64'(0));
            chk({tag, "_drop"},  k, 64'(drop_o[k]), 64'(0));
            chk({tag, "_empty"}, k, 64'(empty_o[k]), 64'(4'hF));
        end
    endtask

    // Asynchronous reset mid-cycle; model and scoreboards are discarded.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        for (int k = 0; k < NC; k++) begin
            exp_rd[k].delete();
            exp_drop[k].delete();
            for (int c = 0; c < 4; c++) begin
                mq[k][c].delete();
                sc[k][c] = 0;
            end
        end
        #1;
        check_idle_outputs("rst_assert");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_idle_outputs("rst_release");
        for (int k = 0; k < NC; k++) chk("rst_full", k, 64'(full_o[k]), 64'(0));
    endtask

    // Monitor: compare every registered response against the scoreboards.
    always @(negedge clk) begin : monitor
        rd_exp_t e;
        bit      en;
        for (int k = 0; k < NC; k++) begin
            en = (exp_rd[k].size() > 0) && (exp_rd[k][0].stamp == 32'(cyc));
            chk("rd_valid", k, 64'(rdv_o[k]), 64'(en));
            if (en) begin
                e = exp_rd[k].pop_front();
                chk("rd_data", k, 64'(rdd_o[k]), 64'(e.data));
                chk("rd_qos",  k, 64'(rdq_o[k]), 64'(e.ch));
            end else begin
                chk("rd_idle_data", k, 64'(rdd_o[k]), 64'(0));
                chk("rd_idle_qos",  k, 64'(rdq_o[k]), 64'(0));
            end
            en = (exp_drop[k].size() > 0) && (exp_drop[k][0] == cyc);
            chk("drop", k, 64'(drop_o[k]), 64'(en));
            if (en) void'(exp_drop[k].pop_front());
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        do_reset();

        // Reset with traffic in flight, then pops on an empty bank.
        for (int i = 0; i < 6; i++) step(1'b1, 32'h100 + 32'(i), 3'(i % 4), 1'b0);
        step(1'b1, 32'h1FF, 3'd2, 1'b1);
        do_reset();
        drain(3);

        // Strict priority.
        step(1'b1, 32'hA0, 3'd0, 1'b0);
        step(1'b1, 32'hB1, 3'd1, 1'b0);
        step(1'b1, 32'hC3, 3'd3, 1'b0);
        drain(4);

        // Spill and drop: 13 writes to QoS 2.
        for (int i = 0; i < 13; i++) step(1'b1, 32'hE0 + 32'(i), 3'd2, 1'b0);
        drain(16);

        // Wrap-around with concurrent write and pop on ch1.
        for (int i = 0; i < 20; i++) step(1'b1, 32'(i), 3'd1, 1'b1);
        drain(3);

        // Starvation relief: ch0 holds one entry while ch3 is kept fed.
        step(1'b1, 32'h55, 3'd0, 1'b0);
        step(1'b1, 32'h300, 3'd3, 1'b0);
        step(1'b1, 32'h301, 3'd3, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 32'h310 + 32'(i), 3'd3, 1'b1);
        drain(8);

        // Full-write/pop collision on ch0.
        for (int i = 0; i < 4; i++) step(1'b1, 32'hD0 + 32'(i), 3'd0, 1'b0);
        step(1'b1, 32'hD4, 3'd0, 1'b1);
        drain(6);

        // Randomized traffic including clamped QoS values.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) < 6), $urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1));
        end
        drain(20);

        wr = 1'b0;
        rd = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NC; k++) begin
            chk("leftover_rd",   k, 64'(exp_rd[k].size()), 64'(0));
            chk("leftover_drop", k, 64'(exp_drop[k].size()), 64'(0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
